// File: rtl/data_mem_ctrl.sv
// Data memory for the single-cycle ARM datapath.
// Little-endian byte/halfword/word access, sign/zero-extended loads, fault
// detection, optional registered read, and a self-clear sequence after reset.
module data_mem_ctrl #(
  parameter int          ADDR_WIDTH   = 7,
  parameter int          READ_LATENCY = 0,
  parameter logic [31:0] INIT_VALUE   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Address,
  input  logic        WE,
  input  logic [1:0]  Size,
  input  logic        Signed,
  input  logic [31:0] WD,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Fault
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  clr_we;

  logic [31:0]           mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            off;
  logic                  fault_raw;
  logic                  wr_en;
  logic [3:0]            be;
  logic [31:0]           wd_lane;
  logic [31:0]           rd_word;
  logic [31:0]           rd_comb;

  // Right-align the addressed lane(s) and extend; word loads ignore sext.
  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [1:0]  sz,
                                           input logic        sext);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {lane, 3'b000};
    case (sz)
      2'b00:   r = {{24{sext & sh[7]}},  sh[7:0]};
      2'b01:   r = {{16{sext & sh[15]}}, sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  assign idx  = Address[ADDR_WIDTH+1:2];
  assign off  = Address[1:0];
  assign Busy = (state == CLEAR);

  // Upper-bit check uses a shift so it stays legal for any ADDR_WIDTH.
  assign fault_raw = (Size == 2'b11)
                   | ((Size == 2'b01) & Address[0])
                   | ((Size == 2'b10) & (|Address[1:0]))
                   | ((Address >> (ADDR_WIDTH + 2)) != 32'd0);

  assign Fault = fault_raw & ~Busy;
  assign wr_en = WE & ~Busy & ~fault_raw;

  // Byte-enable and replicated write data for the addressed lanes.
  always_comb begin
    be      = 4'b0000;
    wd_lane = WD;
    case (Size)
      2'b00: begin
        be      = 4'b0001 << off;
        wd_lane = {4{WD[7:0]}};
      end
      2'b01: begin
        be      = off[1] ? 4'b1100 : 4'b0011;
        wd_lane = {2{WD[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Clear FSM state and counter register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Clear FSM next-state: sweep every word once, then idle until reset.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (&cnt) state_nxt = IDLE;
      end
      IDLE:    state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // Array update: clear sweep has priority; reset blocks all writes.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (clr_we) begin
        mem[cnt] <= INIT_VALUE;
      end else if (wr_en) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wd_lane[8*i +: 8];
        end
      end
    end
  end

  assign rd_word = mem[idx];
  assign rd_comb = (Busy | fault_raw) ? 32'd0 : load_ext(rd_word, off, Size, Signed);

  // ---- read stage boundary: combinational or one registered stage ----
  generate
    if (READ_LATENCY == 0) begin : g_rd_comb
      assign ReadData = rd_comb;
    end else begin : g_rd_reg
      logic [31:0] rd_p1;
      // Registered read samples pre-write array contents (read-first).
      always_ff @(posedge CLK) begin
        if (RESET) rd_p1 <= 32'd0;
        else       rd_p1 <= rd_comb;
      end
      assign ReadData = rd_p1;
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: combinational and registered-read instances share
// stimulus and are compared against a byte-array reference model.
module tb_data_mem_ctrl;

  localparam int          AW   = 7;
  localparam int          NW   = 2 ** AW;
  localparam int          NB   = 4 * NW;
  localparam logic [31:0] INIT = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, we, sg;
  logic [31:0] addr, wd;
  logic [1:0]  sz;
  logic [31:0] rd0, rd1;
  logic        bsy0, bsy1, flt0, flt1;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_WIDTH(AW), .READ_LATENCY(0), .INIT_VALUE(INIT)) dut0 (
    .CLK(clk), .RESET(rst), .Address(addr), .WE(we), .Size(sz), .Signed(sg),
    .WD(wd), .ReadData(rd0), .Busy(bsy0), .Fault(flt0)
  );

  data_mem_ctrl #(.ADDR_WIDTH(AW), .READ_LATENCY(1), .INIT_VALUE(INIT)) dut1 (
    .CLK(clk), .RESET(rst), .Address(addr), .WE(we), .Size(sz), .Signed(sg),
    .WD(wd), .ReadData(rd1), .Busy(bsy1), .Fault(flt1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory as a little-endian byte array.
  bit [7:0]    mb [NB];
  bit          busy_m  = 1'b1;
  int          clr_pos = 0;
  logic [31:0] rd1_m   = 32'd0;
  bit          mvalid  = 1'b0;

  logic [31:0] ob_rd0, ob_rd1;
  logic        ob_flt, ob_bsy;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit m_fault(input logic [31:0] a, input logic [1:0] s);
    if (busy_m) return 1'b0;
    if (s == 2'd3) return 1'b1;
    if (s == 2'd1 && a % 2 != 0) return 1'b1;
    if (s == 2'd2 && a % 4 != 0) return 1'b1;
    if (a >= 32'(NB)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] s, input bit g);
    longint v;
    int     n;
    if (busy_m || m_fault(a, s)) return 32'd0;
    n = nbytes(s);
    v = 0;
    for (int k = 0; k < n; k++) v = v | (longint'(mb[int'(a) + k]) << (8 * k));
    if (g && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic cycle(input bit r, input bit w, input logic [31:0] a,
                       input logic [1:0] s, input bit g, input logic [31:0] d);
    logic [31:0] e;
    bit          f;
    rst = r; we = w; addr = a; sz = s; sg = g; wd = d;
    @(negedge clk);
    ob_rd0 = rd0; ob_rd1 = rd1; ob_flt = flt0; ob_bsy = bsy0;
    e = m_read(a, s, g);
    f = m_fault(a, s);
    if (mvalid) begin
      check_val("busy0", 32'(bsy0), 32'(busy_m));
      check_val("busy1", 32'(bsy1), 32'(busy_m));
      check_val("fault0", 32'(flt0), 32'(f));
      check_val("fault1", 32'(flt1), 32'(f));
      check_val("rdata0", rd0, e);
      check_val("rdata1", rd1, rd1_m);
    end
    @(posedge clk);
    if (r) begin
      busy_m = 1'b1; clr_pos = 0; rd1_m = 32'd0; mvalid = 1'b1;
    end else begin
      rd1_m = e;
      if (busy_m) begin
        for (int k = 0; k < 4; k++) mb[clr_pos * 4 + k] = 8'(INIT >> (8 * k));
        clr_pos++;
        if (clr_pos == NW) busy_m = 1'b0;
      end else if (w && !f) begin
        for (int k = 0; k < nbytes(s); k++) mb[int'(a) + k] = 8'(d >> (8 * k));
      end
    end
    #1;
  endtask

  task automatic rand_cycle(input bit r);
    logic [1:0]  s;
    logic [31:0] a;
    int          p;
    s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    p = $urandom_range(0, 9);
    if (p == 0)      a = $urandom;
    else if (p == 1) a = 32'(NB) + 32'($urandom_range(0, 63));
    else             a = 32'($urandom_range(0, NB - 1));
    if (s != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~32'(nbytes(s) - 1);
    cycle(r, 1'($urandom_range(0, 1)), a, s, 1'($urandom_range(0, 1)), $urandom);
  endtask

  task automatic count_clear(input string tag);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      rand_cycle(1'b0);
      if (ob_bsy) cnt++;
      else break;
    end
    check_val(tag, 32'(cnt), 32'(NW));
  endtask

  initial begin
    // Reset pulse and first clear sweep
    cycle(1'b1, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0, 2'd2, 1'b0, 32'hFFFF_FFFF);
    check_val("rst_busy", 32'(ob_bsy), 32'd1);
    check_val("rst_fault", 32'(ob_flt), 32'd0);
    check_val("rst_rd0", ob_rd0, 32'd0);
    check_val("rst_rd1", ob_rd1, 32'd0);
    count_clear("clr_len");

    cycle(1'b0, 1'b0, 32'h000, 2'd2, 1'b0, 32'h0);
    check_val("clr_0x000", ob_rd0, INIT);
    cycle(1'b0, 1'b0, 32'h1FC, 2'd2, 1'b0, 32'h0);
    check_val("clr_0x1fc", ob_rd0, INIT);

    // Byte lanes
    cycle(1'b0, 1'b1, 32'h10, 2'd2, 1'b0, 32'h1122_3344);
    cycle(1'b0, 1'b1, 32'h12, 2'd0, 1'b0, 32'h0000_00AB);
    cycle(1'b0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    check_val("byte_lane", ob_rd0, 32'h11AB_3344);
    cycle(1'b0, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
    check_val("byte_lane_reg", ob_rd1, 32'h11AB_3344);

    // Extension
    cycle(1'b0, 1'b1, 32'h20, 2'd2, 1'b0, 32'h0000_80F0);
    cycle(1'b0, 1'b0, 32'h20, 2'd1, 1'b1, 32'h0);
    check_val("half_sext", ob_rd0, 32'hFFFF_80F0);
    cycle(1'b0, 1'b0, 32'h20, 2'd1, 1'b0, 32'h0);
    check_val("half_zext", ob_rd0, 32'h0000_80F0);
    cycle(1'b0, 1'b0, 32'h20, 2'd0, 1'b1, 32'h0);
    check_val("byte_sext", ob_rd0, 32'hFFFF_FFF0);

    // Faults
    cycle(1'b0, 1'b1, 32'h22, 2'd2, 1'b0, 32'hDEAD_BEEF);
    check_val("flt_word_mis", 32'(ob_flt), 32'd1);
    cycle(1'b0, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
    check_val("word8_keep", ob_rd0, 32'h0000_80F0);
    cycle(1'b0, 1'b0, 32'h21, 2'd1, 1'b0, 32'h0);
    check_val("flt_half_mis", 32'(ob_flt), 32'd1);
    cycle(1'b0, 1'b1, 32'h0, 2'd3, 1'b0, 32'h1234_5678);
    check_val("flt_size3", 32'(ob_flt), 32'd1);
    cycle(1'b0, 1'b0, 32'h200, 2'd2, 1'b0, 32'h0);
    check_val("flt_range", 32'(ob_flt), 32'd1);
    check_val("flt_range_rd", ob_rd0, 32'd0);

    // Registered read is read-first
    cycle(1'b0, 1'b1, 32'h04, 2'd2, 1'b0, 32'h1234_5678);
    cycle(1'b0, 1'b1, 32'h04, 2'd2, 1'b0, 32'h5555_5555);
    cycle(1'b0, 1'b0, 32'h04, 2'd2, 1'b0, 32'h0);
    check_val("rl1_old", ob_rd1, 32'h1234_5678);
    check_val("rl0_new", ob_rd0, 32'h5555_5555);
    cycle(1'b0, 1'b0, 32'h04, 2'd2, 1'b0, 32'h0);
    check_val("rl1_new", ob_rd1, 32'h5555_5555);

    // Random traffic
    for (int i = 0; i < 1500; i++) rand_cycle(1'b0);

    // Mid-clear reset with a colliding write
    rand_cycle(1'b1);
    rand_cycle(1'b1);
    for (int i = 0; i < 50; i++) rand_cycle(1'b0);
    cycle(1'b1, 1'b1, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D);
    count_clear("clr_len_restart");
    cycle(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
    check_val("restart_w0", ob_rd0, INIT);

    for (int i = 0; i < 400; i++) rand_cycle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
